// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with BCD time, run/pause/adjust FSM and a 4-digit multiplexed
// 7-segment driver; the field being adjusted blinks while it is selected.
module stopwatch_core #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int MAX_MIN   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_p,
    input  logic       sel_p,
    input  logic       adj_p,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] P_TC   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_TC   = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] B_TC   = BW'(BLINK_DIV - 1);
    localparam logic [3:0]    MAX_HI = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_LO = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        ADJ_MIN = 2'd2,
        ADJ_SEC = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
    logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    logic       run_cnt, step_sec, sec_at_max, min_at_max;
    logic       inc_sec, inc_min, entering_adj, blank;
    logic [3:0] digit;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'h40;
            4'd1:    seg_lut = 7'h79;
            4'd2:    seg_lut = 7'h24;
            4'd3:    seg_lut = 7'h30;
            4'd4:    seg_lut = 7'h19;
            4'd5:    seg_lut = 7'h12;
            4'd6:    seg_lut = 7'h02;
            4'd7:    seg_lut = 7'h78;
            4'd8:    seg_lut = 7'h00;
            4'd9:    seg_lut = 7'h10;
            default: seg_lut = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (sel_p) state_d = ADJ_MIN; else if (pause_p) state_d = PAUSED;
            PAUSED:  if (sel_p) state_d = ADJ_MIN; else if (pause_p) state_d = RUN;
            ADJ_MIN: if (sel_p) state_d = ADJ_SEC;
            ADJ_SEC: if (sel_p) state_d = PAUSED;
            default: state_d = PAUSED;
        endcase
    end

    // The prescaler only runs while RUN is both current and next state, so
    // leaving RUN clears it and suppresses a tick on the leaving edge.
    always_comb begin
        run_cnt    = (state_q == RUN) && (state_d == RUN);
        step_sec   = run_cnt && (presc_q == P_TC);
        presc_d    = (run_cnt && !step_sec) ? presc_q + PW'(1) : '0;
        sec_at_max = (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);
        min_at_max = (min_hi_q == MAX_HI) && (min_lo_q == MAX_LO);
        inc_sec    = step_sec || ((state_q == ADJ_SEC) && adj_p);
        inc_min    = (step_sec && sec_at_max) || ((state_q == ADJ_MIN) && adj_p);
        tick_d     = step_sec;
        wrap_d     = step_sec && sec_at_max && min_at_max;
        sec_lo_d   = sec_lo_q;
        sec_hi_d   = sec_hi_q;
        min_lo_d   = min_lo_q;
        min_hi_d   = min_hi_q;
        if (inc_sec) begin
            if (sec_lo_q == 4'd9) begin
                sec_lo_d = 4'd0;
                sec_hi_d = (sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1;
            end else begin
                sec_lo_d = sec_lo_q + 4'd1;
            end
        end
        if (inc_min) begin
            if (min_at_max) begin
                min_lo_d = 4'd0;
                min_hi_d = 4'd0;
            end else if (min_lo_q == 4'd9) begin
                min_lo_d = 4'd0;
                min_hi_d = min_hi_q + 4'd1;
            end else begin
                min_lo_d = min_lo_q + 4'd1;
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == S_TC) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        entering_adj = ((state_d == ADJ_MIN) || (state_d == ADJ_SEC)) && (state_d != state_q);
        blink_cnt_d  = blink_cnt_q + BW'(1);
        blink_off_d  = blink_off_q;
        if (entering_adj) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == B_TC) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    // Anode, segments and dp all derive from idx_q in one cycle so they stay aligned.
    always_comb begin
        case (idx_q)
            2'd0:    digit = sec_lo_q;
            2'd1:    digit = sec_hi_q;
            2'd2:    digit = min_lo_q;
            default: digit = min_hi_q;
        endcase
        blank = blink_off_q && (((state_q == ADJ_MIN) &&  idx_q[1]) ||
                                ((state_q == ADJ_SEC) && !idx_q[1]));
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? 7'h7F : seg_lut(digit);
        dp_d  = !((idx_q == 2'd2) && !((state_q == PAUSED) && blink_off_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAUSED;
            presc_q     <= '0;
            sec_lo_q    <= '0;
            sec_hi_q    <= '0;
            min_lo_q    <= '0;
            min_hi_q    <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            an_q        <= 4'b1110;
            seg_q       <= 7'h40;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_lo_q    <= sec_lo_d;
            sec_hi_q    <= sec_hi_d;
            min_lo_q    <= min_lo_d;
            min_hi_q    <= min_hi_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: tick/time scoreboard plus direct display and FSM checks,
// with a second instance at MAX_MIN=5 for the short-wrap case.
module tb_stopwatch_core;

    localparam logic [1:0] S_PAUSED = 2'd1, S_ADJ_MIN = 2'd2, S_ADJ_SEC = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause_a = 1'b0, sel_a = 1'b0, adj_a = 1'b0;
    logic pause_b = 1'b0, sel_b = 1'b0, adj_b = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic dp_a, dp_b, tick_a, tick_b, wrap_a, wrap_b;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;
    int cyc = 0;
    logic [16:0] sb[$];

    stopwatch_core #(.TICK_DIV(10), .SCAN_DIV(2), .BLINK_DIV(4), .MAX_MIN(99)) dut_a (
        .clk(clk), .rst(rst), .pause_p(pause_a), .sel_p(sel_a), .adj_p(adj_a),
        .seg(seg_a), .dp(dp_a), .an(an_a), .tick(tick_a), .wrap(wrap_a));

    stopwatch_core #(.TICK_DIV(10), .SCAN_DIV(2), .BLINK_DIV(4), .MAX_MIN(5)) dut_b (
        .clk(clk), .rst(rst), .pause_p(pause_b), .sel_p(sel_b), .adj_p(adj_b),
        .seg(seg_b), .dp(dp_b), .an(an_b), .tick(tick_b), .wrap(wrap_b));

    logic [15:0] t_a, t_b;
    assign t_a = {dut_a.min_hi_q, dut_a.min_lo_q, dut_a.sec_hi_q, dut_a.sec_lo_q};
    assign t_b = {dut_b.min_hi_q, dut_b.min_lo_q, dut_b.sec_hi_q, dut_b.sec_lo_q};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Scoreboard: every tick from dut_a must match the next queued {wrap, time}.
    always @(negedge clk) begin
        if (!rst) begin
            if (tick_a) begin
                tick_cnt++;
                if (sb.size() == 0) check("sb_unexpected_tick", 32'(sb.size()), 32'd1);
                else check("sb_tick", {15'd0, wrap_a, t_a}, {15'd0, sb.pop_front()});
            end else if (wrap_a) begin
                check("wrap_without_tick", 32'(wrap_a), 32'd0);
            end
        end
    end

    task automatic pulse_a(input logic [2:0] v);
        @(posedge clk); #1 {pause_a, sel_a, adj_a} = v;
        @(posedge clk); #1 {pause_a, sel_a, adj_a} = 3'b000;
    endtask

    task automatic pulse_b(input logic [2:0] v);
        @(posedge clk); #1 {pause_b, sel_b, adj_b} = v;
        @(posedge clk); #1 {pause_b, sel_b, adj_b} = 3'b000;
    endtask

    task automatic adj_n_a(input int n);
        for (int i = 0; i < n; i++) pulse_a(3'b001);
    endtask

    task automatic adj_n_b(input int n);
        for (int i = 0; i < n; i++) pulse_b(3'b001);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_ticks(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tick_cnt >= target) break;
        end
        check("tick_wait_budget", 32'(tick_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, lat, es, k, nblank;
        logic [6:0] exp_seg;
        logic [3:0] prev_an;
        logic blank_exp, saw_dp0, got;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 32'(an_a), 32'h0E);
        check("rst_seg", 32'(seg_a), 32'h40);
        check("rst_dp", 32'(dp_a), 32'd1);
        check("rst_tick", 32'(tick_a), 32'd0);
        check("rst_wrap", 32'(wrap_a), 32'd0);
        check("rst_state", 32'(dut_a.state_q), 32'(S_PAUSED));
        check("rst_time", 32'(t_a), 32'h0000);
        @(posedge clk); #1 rst = 1'b0;

        // First tick latency and one minute of run time
        for (int s = 1; s <= 60; s++) sb.push_back({1'b0, to_bcd(s)});
        pulse_a(3'b100);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (tick_a) begin
                lat = n - 1;
                break;
            end
        end
        check("first_tick_latency", 32'(lat), 32'd10);
        wait_ticks(60, 700);
        check("time_after_60s", 32'(t_a), 32'h0100);

        // sel beats pause in RUN; time frozen and prescaler held
        pulse_a(3'b110);
        check("selpause_state", 32'(dut_a.state_q), 32'(S_ADJ_MIN));
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("adjmin_presc", 32'(dut_a.presc_q), 32'd0);
        check("adjmin_frozen", 32'(t_a), 32'h0100);
        check("adjmin_state", 32'(dut_a.state_q), 32'(S_ADJ_MIN));

        // Adjust sequence to 03:01, then verify seconds blinking against a phase model
        do_reset();
        pulse_a(3'b010);
        adj_n_a(3);
        pulse_a(3'b010);
        es = cyc;
        adj_n_a(61);
        check("adjsec_state", 32'(dut_a.state_q), 32'(S_ADJ_SEC));
        check("adjsec_time", 32'(t_a), 32'h0301);
        nblank = 0;
        repeat (32) begin
            @(negedge clk);
            k = cyc - es;
            blank_exp = (an_a == 4'b1110 || an_a == 4'b1101) && ((((k - 1) / 4) % 2) == 1);
            case (an_a)
                4'b1110: exp_seg = 7'h79;
                4'b1101: exp_seg = 7'h40;
                4'b1011: exp_seg = 7'h30;
                default: exp_seg = 7'h40;
            endcase
            if (blank_exp) begin
                exp_seg = 7'h7F;
                nblank++;
            end
            check("adjsec_seg", 32'(seg_a), 32'(exp_seg));
        end
        check("adjsec_blank_windows", 32'(nblank > 0), 32'd1);

        // Display scan at 12:34 (paused)
        do_reset();
        pulse_a(3'b010);
        adj_n_a(12);
        pulse_a(3'b010);
        adj_n_a(34);
        pulse_a(3'b010);
        check("scan_state", 32'(dut_a.state_q), 32'(S_PAUSED));
        check("scan_time", 32'(t_a), 32'h1234);
        @(negedge clk);
        prev_an = an_a;
        saw_dp0 = 1'b0;
        repeat (16) begin
            @(negedge clk);
            case (an_a)
                4'b1110: exp_seg = 7'h19;
                4'b1101: exp_seg = 7'h30;
                4'b1011: exp_seg = 7'h24;
                4'b0111: exp_seg = 7'h79;
                default: exp_seg = 7'h7F;
            endcase
            check("scan_seg", {25'd0, seg_a}, {25'd0, exp_seg});
            if (an_a != prev_an) check("scan_rotate", 32'(an_a), 32'({prev_an[2:0], prev_an[3]}));
            prev_an = an_a;
            if (an_a != 4'b1011) check("scan_dp_off", 32'(dp_a), 32'd1);
            else if (!dp_a) saw_dp0 = 1'b1;
        end
        check("scan_dp_sep_seen", 32'(saw_dp0), 32'd1);

        // Minutes modulo 100 and the 99:59 -> 00:00 wrap
        do_reset();
        pulse_a(3'b010);
        adj_n_a(100);
        check("min_mod100", 32'(t_a), 32'h0000);
        adj_n_a(99);
        check("min_99", 32'(t_a), 32'h9900);
        pulse_a(3'b010);
        adj_n_a(59);
        pulse_a(3'b010);
        check("preload_9959", 32'(t_a), 32'h9959);
        sb.push_back({1'b1, 16'h0000});
        base = tick_cnt;
        pulse_a(3'b100);
        wait_ticks(base + 1, 30);
        @(negedge clk);
        check("wrap_one_cycle", 32'(wrap_a), 32'd0);
        pulse_a(3'b100);

        // Reset in the middle of RUN at 00:07
        do_reset();
        for (int s = 1; s <= 7; s++) sb.push_back({1'b0, to_bcd(s)});
        base = tick_cnt;
        pulse_a(3'b100);
        wait_ticks(base + 7, 100);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_time", 32'(t_a), 32'h0000);
        check("midrst_state", 32'(dut_a.state_q), 32'(S_PAUSED));
        check("midrst_an", 32'(an_a), 32'h0E);
        check("midrst_seg", 32'(seg_a), 32'h40);
        check("midrst_tick", 32'(tick_a), 32'd0);
        check("midrst_presc", 32'(dut_a.presc_q), 32'd0);
        rst = 1'b0;

        // MAX_MIN=5 instance: minutes modulo 6 and 05:59 wrap
        pulse_b(3'b010);
        adj_n_b(6);
        check("b_min_mod6", 32'(t_b), 32'h0000);
        adj_n_b(5);
        pulse_b(3'b010);
        adj_n_b(59);
        pulse_b(3'b010);
        check("b_preload_0559", 32'(t_b), 32'h0559);
        pulse_b(3'b100);
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (tick_b) begin
                got = 1'b1;
                break;
            end
        end
        check("b_tick_seen", 32'(got), 32'd1);
        check("b_wrap", 32'(wrap_b), 32'd1);
        check("b_time_wrapped", 32'(t_b), 32'h0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000: clk cycles per count tick (1 Hz at 100 MHz).
REQ-002 Parameter SCAN_DIV, default 100_000: clk cycles per display digit slot.
REQ-003 Parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period (2 Hz blink at 100 MHz).
REQ-004 Parameter MAX_MIN, default 99, legal range 1..99: highest minutes value before wrap.
REQ-005 Port clk  in  1: the only clock; all state changes on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-high.
REQ-007 Port pause_p  in  1: one-cycle pulse (debounced upstream) toggling run/pause.
REQ-008 Port sel_p  in  1: one-cycle pulse advancing the adjust selection.
REQ-009 Port adj_p  in  1: one-cycle pulse incrementing the selected field.
REQ-010 Port seg  out  7: cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp  out  1: decimal point, active-low.
REQ-012 Port an  out  4: digit anodes, active-low one-hot; an[0] is the rightmost digit.
REQ-013 Port tick  out  1: one-cycle strobe on every time increment in RUN.
REQ-014 Port wrap  out  1: one-cycle strobe when time wraps from MAX_MIN:59 to 00:00.

Function
REQ-015 Time SHALL be held as four BCD digits: sec_lo 0..9, sec_hi 0..5, min_lo, min_hi, with minutes in the range 0..MAX_MIN.
REQ-016 The FSM SHALL have the states RUN, PAUSED, ADJ_MIN and ADJ_SEC.
REQ-017 FSM transitions: pause_p toggles RUN<->PAUSED; sel_p goes RUN/PAUSED->ADJ_MIN->ADJ_SEC->PAUSED.
REQ-018 Priority: sel_p beats pause_p in the same cycle; pause_p is ignored in ADJ_*; adj_p is ignored outside ADJ_*.
REQ-019 The prescaler SHALL count only in RUN and SHALL be held at 0 in every other state.
- First increment occurs exactly TICK_DIV cycles after the cycle RUN is entered.
REQ-020 On prescaler terminal count (TICK_DIV-1), time SHALL increment by one second and tick SHALL assert for 1 cycle.
- Digit carries ripple in the same cycle: 9->0 sec_lo, 5->0 sec_hi, and carry into the minutes.
REQ-021 When incrementing from MAX_MIN:59, time SHALL become 00:00 and wrap SHALL assert in the same cycle as tick.
REQ-022 In ADJ_MIN, adj_p SHALL increment the minutes modulo (MAX_MIN+1), leave the seconds unchanged, and not assert tick or wrap.
REQ-023 In ADJ_SEC, adj_p SHALL increment the seconds modulo 60, with no carry into the minutes and no strobes.
REQ-024 Scan counter: the digit index 0..3 SHALL advance every SCAN_DIV cycles in all states, wrapping 3->0.
REQ-025 an, seg and dp SHALL be registered from the same digit index in the same cycle, so anode and segment data never mismatch.
REQ-026 Digit index i SHALL drive an = ~(1<<i) and show digit i: 0=sec_lo, 1=sec_hi, 2=min_lo, 3=min_hi.
REQ-027 Segment patterns 0-9 SHALL be: 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit).
REQ-028 dp SHALL be 0 while index 2 is active (minutes:seconds separator) and 1 otherwise.
- In PAUSED, dp SHALL be forced to 1 during the blink off-phase.
REQ-029 Blink phase SHALL toggle every BLINK_DIV cycles and SHALL reset to the on-phase on entry to ADJ_MIN or ADJ_SEC.
REQ-030 During the blink off-phase in ADJ_MIN, digits 2-3 SHALL show seg=7F; in ADJ_SEC, digits 0-1 SHALL show 7F.
REQ-031 Non-selected digits SHALL always display normally.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL load the following values, overriding all other inputs:
- state=PAUSED, time=00:00, all counters 0, blink on-phase.
- an=1110, seg=40, dp=1, tick=0, wrap=0.
REQ-033 Reset asserted mid-count or mid-adjust SHALL discard the time and prescaler with no tick or wrap emitted.

Verification (TICK_DIV=10, SCAN_DIV=2, BLINK_DIV=4, MAX_MIN=99 unless noted)
REQ-034 Release rst, pulse pause_p -> tick asserts exactly 10 cycles later; time reads 00:01; after 600 cycles, 01:00.
REQ-035 Preload 99:59 via adjust, then run -> next tick reads 00:00 with wrap=1 on the same cycle; with MAX_MIN=5, 05:59 also wraps to 00:00.
REQ-036 sel_p, adj_p x3, sel_p, adj_p x61 -> state ADJ_SEC, time 03:01, no tick/wrap pulses; digits 0-1 blank every other 4-cycle window.
REQ-037 Same-cycle sel_p+pause_p in RUN -> ADJ_MIN entered, prescaler held at 0, time frozen.
REQ-038 Monitor an/seg over 8 scan slots at time 12:34 -> an sequence 1110,1101,1011,0111 with seg 19,30,24,79; dp=0 only with an=1011.
REQ-039 Assert rst mid-RUN at 00:07 -> next cycle: time 00:00, PAUSED, an=1110, seg=40, tick=0.
